// File: rtl/lsu_pkg.sv
`default_nettype none
//==============================================================================
// Package     : lsu_pkg
// Description : Shared AXI encodings and load-engine state encoding for the
//               LSU load path.
// Revision    : 1.0 - initial release
//==============================================================================
package lsu_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_ar    = 2'd1;
    localparam logic [1:0] c_st_rd    = 2'd2;
    localparam logic [1:0] c_st_flush = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        AR    = c_st_ar,
        RD    = c_st_rd,
        FLUSH = c_st_flush
    } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_beat_packer.sv
`default_nettype none
//==============================================================================
// Module      : lsu_beat_packer
// Description : Packs RATIO consecutive AXI_DW-bit beats into one word, LSB
//               slot first. A word completes on its last slot or on a beat
//               flagged last; unfilled upper slots of such a word read as 0.
// Ports       : clk, rst          clock, synchronous active-high reset
//               i_push            beat accepted this cycle
//               i_last            accepted beat ends the burst
//               i_data            beat payload
//               o_complete        word completes with this push
//               o_word            word contents including the current beat
// Revision    : 1.0 - initial release
//==============================================================================
module lsu_beat_packer #(
    parameter int RATIO  = 2,
    parameter int AXI_DW = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_last,
    input  logic [AXI_DW-1:0]       i_data,
    output logic                    o_complete,
    output logic [RATIO*AXI_DW-1:0] o_word
);

    localparam int                SLOT_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(RATIO - 1);

    logic [SLOT_W-1:0]       r_slot;
    logic [RATIO*AXI_DW-1:0] r_word;
    logic [RATIO*AXI_DW-1:0] w_word;

    // Slots above r_slot are always zero in r_word (cleared on completion),
    // so a word cut short by i_last needs no extra masking.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
            assign w_word[gi*AXI_DW +: AXI_DW] =
                (r_slot == SLOT_W'(gi)) ? i_data : r_word[gi*AXI_DW +: AXI_DW];
        end
    endgenerate

    assign o_complete = i_push && ((r_slot == c_last_slot) || i_last);
    assign o_word     = w_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
            r_word <= '0;
        end else if (i_push) begin
            if (o_complete) begin
                r_slot <= '0;
                r_word <= '0;
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
                r_word <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ld_engine.sv
`default_nettype none
//==============================================================================
// Module      : lsu_ld_engine
// Description : DRAM->SRAM load engine. One command issues cmd_num+1 AXI INCR
//               read bursts of cmd_len+1 beats, bases spaced by cmd_str bytes,
//               one burst outstanding at a time. Beats are packed into SRAM
//               words and written to scratchpad cmd_sel via a cen/gnt port.
// Ports       : clk, rst_n        clock, synchronous active-high reset
//               cmd_*             load command (vld/rdy handshake)
//               axi_ar*           AXI read-address channel (master)
//               axi_r*            AXI read-data channel (master)
//               sram_cen/gnt      one-hot write request / grant per RAM
//               sram_wen/addr/din shared write payload
//               done, err         completion pulse and its error flag
// Revision    : 1.0 - initial release
//==============================================================================
module lsu_ld_engine
    import lsu_pkg::*;
#(
    parameter int  AXI_DW  = 64,
    parameter int  SRAM_DW = 128,
    parameter int  SRAM_AW = 8,
    parameter int  NUM_RAM = 2,
    parameter int  DRAM_AW = 31,
    parameter int  ID_W    = 8,
    parameter int  STR_W   = 12,
    localparam int SEL_W   = (NUM_RAM > 1) ? $clog2(NUM_RAM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic [DRAM_AW-1:0] cmd_dram_addr,
    input  logic [7:0]         cmd_len,
    input  logic [7:0]         cmd_num,
    input  logic [STR_W-1:0]   cmd_str,
    input  logic [SRAM_AW-1:0] cmd_sram_addr,
    input  logic [SEL_W-1:0]   cmd_sel,
    output logic [ID_W-1:0]    axi_arid,
    output logic [DRAM_AW-1:0] axi_araddr,
    output logic [7:0]         axi_arlen,
    output logic [2:0]         axi_arsize,
    output logic [1:0]         axi_arburst,
    output logic               axi_arvld,
    input  logic               axi_arrdy,
    input  logic [ID_W-1:0]    axi_rid,
    input  logic [AXI_DW-1:0]  axi_rdata,
    input  logic [1:0]         axi_rresp,
    input  logic               axi_rlast,
    input  logic               axi_rvld,
    output logic               axi_rrdy,
    output logic [NUM_RAM-1:0] sram_cen,
    input  logic [NUM_RAM-1:0] sram_gnt,
    output logic               sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_din,
    output logic               done,
    output logic               err
);

    localparam int         RATIO    = SRAM_DW / AXI_DW;
    localparam logic [2:0] c_arsize = 3'($clog2(AXI_DW / 8));

    ld_state_e          r_state;
    logic [ID_W-1:0]    r_id_cnt;
    logic [ID_W-1:0]    r_arid;
    logic [DRAM_AW-1:0] r_araddr;
    logic [7:0]         r_len;
    logic [7:0]         r_burst_left;
    logic [STR_W-1:0]   r_str;
    logic [SEL_W-1:0]   r_sel;
    logic [SRAM_AW-1:0] r_cur_addr;
    logic [SRAM_DW-1:0] r_din;
    logic               r_wr_pend;
    logic               r_err;
    logic               r_done;
    logic               r_done_err;

    logic               w_beat_acc;
    logic               w_beat_bad;
    logic               w_gnt_sel;
    logic               w_pack_complete;
    logic [SRAM_DW-1:0] w_pack_word;

    assign w_beat_acc = axi_rvld && axi_rrdy;
    assign w_beat_bad = (axi_rresp != AXI_RESP_OKAY) || (axi_rid != r_arid);
    assign w_gnt_sel  = sram_gnt[r_sel];

    lsu_beat_packer #(
        .RATIO  (RATIO),
        .AXI_DW (AXI_DW)
    ) u_packer (
        .clk        (clk),
        .rst        (rst_n),
        .i_push     (w_beat_acc),
        .i_last     (axi_rlast),
        .i_data     (axi_rdata),
        .o_complete (w_pack_complete),
        .o_word     (w_pack_word)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= IDLE;
            r_id_cnt     <= '0;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_len        <= '0;
            r_burst_left <= '0;
            r_str        <= '0;
            r_sel        <= '0;
            r_cur_addr   <= '0;
            r_din        <= '0;
            r_wr_pend    <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_done_err   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;

            // Retire the pending write; cannot collide with a new one because
            // beats are only accepted while no write is pending.
            if (r_wr_pend && w_gnt_sel) begin
                r_wr_pend  <= 1'b0;
                r_cur_addr <= r_cur_addr + SRAM_AW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (cmd_vld) begin
                        r_arid       <= r_id_cnt;
                        r_id_cnt     <= r_id_cnt + ID_W'(1);
                        r_araddr     <= cmd_dram_addr;
                        r_len        <= cmd_len;
                        r_burst_left <= cmd_num;
                        r_str        <= cmd_str;
                        r_sel        <= cmd_sel;
                        r_cur_addr   <= cmd_sram_addr;
                        r_err        <= 1'b0;
                        r_state      <= AR;
                    end
                end
                AR: begin
                    if (axi_arrdy) begin
                        r_state <= RD;
                    end
                end
                RD: begin
                    if (w_beat_acc) begin
                        if (w_beat_bad) begin
                            r_err <= 1'b1;
                        end
                        // A word touched by a bad beat, and everything after
                        // it, is never written.
                        if (w_pack_complete && !r_err && !w_beat_bad) begin
                            r_wr_pend <= 1'b1;
                            r_din     <= w_pack_word;
                        end
                        if (axi_rlast) begin
                            if (r_burst_left != '0) begin
                                r_burst_left <= r_burst_left - 8'd1;
                                r_araddr     <= r_araddr + DRAM_AW'(r_str);
                                r_state      <= AR;
                            end else begin
                                r_state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (!r_wr_pend || w_gnt_sel) begin
                        r_done     <= 1'b1;
                        r_done_err <= r_err;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RAM; gi++) begin : g_cen
            assign sram_cen[gi] = r_wr_pend && (r_sel == SEL_W'(gi));
        end
    endgenerate

    assign cmd_rdy     = (r_state == IDLE);
    assign axi_arvld   = (r_state == AR);
    assign axi_arid    = r_arid;
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_len;
    assign axi_arsize  = axi_arvld ? c_arsize : 3'd0;
    assign axi_arburst = axi_arvld ? AXI_BURST_INCR : 2'b00;
    assign axi_rrdy    = (r_state == RD) && !r_wr_pend;
    assign sram_wen    = r_wr_pend;
    assign sram_addr   = r_cur_addr;
    assign sram_din    = r_din;
    assign done        = r_done;
    assign err         = r_done_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ld_engine.sv
`default_nettype none
//==============================================================================
// Module      : tb_lsu_ld_engine
// Description : Self-checking bench for lsu_ld_engine. A behavioural AXI slave
//               returns address-derived beats; expected AR requests, SRAM
//               writes and done/err are queued when a command is issued and
//               compared as the engine produces them.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_lsu_ld_engine;

    typedef struct {
        logic [30:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [30:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
    } burst_t;

    typedef struct {
        logic         sel;
        logic [7:0]   addr;
        logic [127:0] din;
    } wr_t;

    logic         clk;
    logic         rst_n;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [30:0]  cmd_dram_addr;
    logic [7:0]   cmd_len;
    logic [7:0]   cmd_num;
    logic [11:0]  cmd_str;
    logic [7:0]   cmd_sram_addr;
    logic [0:0]   cmd_sel;
    logic [7:0]   axi_arid;
    logic [30:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_arvld;
    logic         axi_arrdy;
    logic [7:0]   axi_rid;
    logic [63:0]  axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast;
    logic         axi_rvld;
    logic         axi_rrdy;
    logic [1:0]   sram_cen;
    logic [1:0]   sram_gnt;
    logic         sram_wen;
    logic [7:0]   sram_addr;
    logic [127:0] sram_din;
    logic         done;
    logic         err;

    lsu_ld_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_vld       (cmd_vld),
        .cmd_rdy       (cmd_rdy),
        .cmd_dram_addr (cmd_dram_addr),
        .cmd_len       (cmd_len),
        .cmd_num       (cmd_num),
        .cmd_str       (cmd_str),
        .cmd_sram_addr (cmd_sram_addr),
        .cmd_sel       (cmd_sel),
        .axi_arid      (axi_arid),
        .axi_araddr    (axi_araddr),
        .axi_arlen     (axi_arlen),
        .axi_arsize    (axi_arsize),
        .axi_arburst   (axi_arburst),
        .axi_arvld     (axi_arvld),
        .axi_arrdy     (axi_arrdy),
        .axi_rid       (axi_rid),
        .axi_rdata     (axi_rdata),
        .axi_rresp     (axi_rresp),
        .axi_rlast     (axi_rlast),
        .axi_rvld      (axi_rvld),
        .axi_rrdy      (axi_rrdy),
        .sram_cen      (sram_cen),
        .sram_gnt      (sram_gnt),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .done          (done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    // scoreboard queues
    ar_t    ar_exp[$];
    wr_t    wr_exp[$];
    bit     done_exp[$];

    // AXI slave state
    burst_t sq[$];
    burst_t ar_cap;
    int     sbeat    = 0;
    int     beat_tot = 0;
    bit     ar_hs    = 0;
    bit     r_hs     = 0;
    bit     inj_en   = 0;
    int     inj_beat = 0;

    // monitor state
    int           stepc      = 0;
    int           rlast_step = 0;
    int           gnt_mode   = 0;
    int           hold_cnt   = 0;
    bit           got_done   = 0;
    bit           pend_hold  = 0;
    logic [1:0]   prev_cen;
    logic [7:0]   prev_addr;
    logic [127:0] prev_din;
    bit           new_cmd    = 0;
    bit           have_prev  = 0;
    logic [7:0]   prev_id;
    logic [7:0]   cur_id;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bdata(input logic [30:0] a, input int b);
        return {1'b0, a, 24'hC0FFEE, 8'(b)};
    endfunction

    // One clock of bench activity, run at the falling edge.
    task automatic step();
        wr_t        w;
        ar_t        a;
        logic [1:0] ecen;
        @(negedge clk);
        stepc++;

        // retire handshakes from the rising edge just passed
        if (ar_hs) sq.push_back(ar_cap);
        if (r_hs) begin
            axi_rvld = 1'b0;
            beat_tot++;
            if (sbeat == int'(sq[0].len)) begin
                sbeat = 0;
                sq.delete(0);
            end else begin
                sbeat++;
            end
        end

        // write request must hold while not granted; beats stall meanwhile
        if (pend_hold) begin
            check_val("cen_hold", 128'(sram_cen), 128'(prev_cen));
            check_val("addr_hold", 128'(sram_addr), 128'(prev_addr));
            check_val("din_hold", sram_din, prev_din);
        end
        if (sram_cen != 2'b00) check_val("rrdy_while_pend", 128'(axi_rrdy), 128'(0));

        if (done) begin
            got_done = 1'b1;
            check_val("done_expected", 128'(done_exp.size() > 0), 128'(1));
            if (done_exp.size() > 0) begin
                check_val("done_err", 128'(err), 128'(done_exp.pop_front()));
                if (gnt_mode == 0) check_val("done_latency", 128'(stepc - rlast_step), 128'(2));
            end
        end

        // drive slave and arbiter for the next rising edge
        axi_arrdy = ($urandom_range(0, 2) != 0);
        if (!axi_rvld && sq.size() != 0 && $urandom_range(0, 3) != 0) begin
            axi_rvld  = 1'b1;
            axi_rdata = bdata(sq[0].addr, sbeat);
            axi_rlast = (sbeat == int'(sq[0].len));
            axi_rid   = sq[0].id;
            axi_rresp = (inj_en && beat_tot == inj_beat) ? 2'b10 : 2'b00;
        end
        case (gnt_mode)
            0: sram_gnt = 2'b11;
            1: sram_gnt = 2'($urandom_range(0, 3));
            default: begin
                if (sram_cen[1] && hold_cnt < 5) begin
                    sram_gnt = 2'b01;
                    hold_cnt++;
                end else begin
                    sram_gnt = 2'b11;
                    hold_cnt = 0;
                end
            end
        endcase

        // handshakes that the coming rising edge will complete
        ar_hs = axi_arvld && axi_arrdy;
        if (ar_hs) begin
            ar_cap = '{addr: axi_araddr, len: axi_arlen, id: axi_arid};
            check_val("ar_expected", 128'(ar_exp.size() > 0), 128'(1));
            if (ar_exp.size() > 0) begin
                a = ar_exp.pop_front();
                check_val("araddr", 128'(axi_araddr), 128'(a.addr));
                check_val("arlen", 128'(axi_arlen), 128'(a.len));
                check_val("arsize", 128'(axi_arsize), 128'(3));
                check_val("arburst", 128'(axi_arburst), 128'(1));
            end
            if (new_cmd) begin
                if (have_prev) check_val("arid_next_cmd", 128'(axi_arid), 128'(prev_id + 8'd1));
                cur_id    = axi_arid;
                prev_id   = axi_arid;
                have_prev = 1'b1;
                new_cmd   = 1'b0;
            end else begin
                check_val("arid_same_cmd", 128'(axi_arid), 128'(cur_id));
            end
        end
        r_hs = axi_rvld && axi_rrdy;
        if (r_hs && axi_rlast) rlast_step = stepc;

        if ((sram_cen & sram_gnt) != 2'b00) begin
            check_val("wr_expected", 128'(wr_exp.size() > 0), 128'(1));
            if (wr_exp.size() > 0) begin
                w    = wr_exp.pop_front();
                ecen = w.sel ? 2'b10 : 2'b01;
                check_val("wr_cen", 128'(sram_cen), 128'(ecen));
                check_val("wr_wen", 128'(sram_wen), 128'(1));
                check_val("wr_addr", 128'(sram_addr), 128'(w.addr));
                check_val("wr_din", sram_din, w.din);
            end
        end
        pend_hold = (sram_cen != 2'b00) && ((sram_cen & sram_gnt) == 2'b00);
        prev_cen  = sram_cen;
        prev_addr = sram_addr;
        prev_din  = sram_din;
    endtask

    task automatic start_cmd(input logic [30:0] addr, input logic [7:0] len, input logic [7:0] num,
                             input logic [11:0] str, input logic [7:0] saddr, input logic sel,
                             input bit inj, input int ibeat);
        logic [30:0] a;
        logic [7:0]  sa;
        logic [63:0] lo;
        logic [63:0] hi;
        int          g;
        int          cb;
        a  = addr;
        sa = saddr;
        g  = 0;
        for (int k = 0; k <= int'(num); k++) begin
            ar_exp.push_back('{addr: a, len: len});
            for (int j = 0; j <= int'(len); j += 2) begin
                lo = bdata(a, j);
                hi = (j < int'(len)) ? bdata(a, j + 1) : 64'd0;
                cb = g + ((j < int'(len)) ? j + 1 : j);
                if (!inj || cb < ibeat) begin
                    wr_exp.push_back('{sel: sel, addr: sa, din: {hi, lo}});
                    sa = sa + 8'd1;
                end
            end
            g += int'(len) + 1;
            a = a + 31'(str);
        end
        done_exp.push_back(inj);
        inj_en        = inj;
        inj_beat      = ibeat;
        beat_tot      = 0;
        new_cmd       = 1'b1;
        cmd_dram_addr = addr;
        cmd_len       = len;
        cmd_num       = num;
        cmd_str       = str;
        cmd_sram_addr = saddr;
        cmd_sel       = sel;
        cmd_vld       = 1'b1;
        check_val("cmd_rdy_idle", 128'(cmd_rdy), 128'(1));
        step();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_done();
        got_done = 1'b0;
        for (int i = 0; i < 3000 && !got_done; i++) step();
        check_val("done_seen", 128'(got_done), 128'(1));
        check_val("wr_left", 128'(wr_exp.size()), 128'(0));
        check_val("ar_left", 128'(ar_exp.size()), 128'(0));
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b1;
        axi_rvld  = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        sbeat     = 0;
        inj_en    = 1'b0;
        pend_hold = 1'b0;
        have_prev = 1'b0;
        new_cmd   = 1'b0;
        sq.delete();
        ar_exp.delete();
        wr_exp.delete();
        done_exp.delete();
        repeat (n) step();
        rst_n = 1'b0;
    endtask

    task automatic check_quiet();
        check_val("rst_cmd_rdy", 128'(cmd_rdy), 128'(1));
        check_val("rst_arvld", 128'(axi_arvld), 128'(0));
        check_val("rst_rrdy", 128'(axi_rrdy), 128'(0));
        check_val("rst_cen", 128'(sram_cen), 128'(0));
        check_val("rst_done", 128'(done), 128'(0));
    endtask

    initial begin
        rst_n         = 1'b1;
        cmd_vld       = 1'b0;
        cmd_dram_addr = '0;
        cmd_len       = '0;
        cmd_num       = '0;
        cmd_str       = '0;
        cmd_sram_addr = '0;
        cmd_sel       = '0;
        axi_arrdy     = 1'b0;
        axi_rid       = '0;
        axi_rdata     = '0;
        axi_rresp     = '0;
        axi_rlast     = 1'b0;
        axi_rvld      = 1'b0;
        sram_gnt      = 2'b00;

        do_reset(3);
        step();
        check_quiet();
        check_val("rst_wen", 128'(sram_wen), 128'(0));
        check_val("rst_err", 128'(err), 128'(0));
        check_val("rst_din", sram_din, 128'(0));

        // single burst, 4 beats, grant always present
        gnt_mode = 0;
        start_cmd(31'h100, 8'd3, 8'd0, 12'h000, 8'h10, 1'b0, 1'b0, 0);
        wait_done();

        // three strided bursts, random grant
        gnt_mode = 1;
        start_cmd(31'h1000, 8'd1, 8'd2, 12'h040, 8'h20, 1'b1, 1'b0, 0);
        wait_done();

        // odd beat count: last word half filled, next burst restarts at slot 0
        start_cmd(31'h2000, 8'd2, 8'd1, 12'h100, 8'h30, 1'b0, 1'b0, 0);
        wait_done();

        // grant for RAM 1 withheld for 5 cycles per write
        gnt_mode = 2;
        start_cmd(31'h3000, 8'd3, 8'd1, 12'h080, 8'h40, 1'b1, 1'b0, 0);
        wait_done();

        // error response on the second beat
        gnt_mode = 0;
        start_cmd(31'h4000, 8'd3, 8'd0, 12'h000, 8'h50, 1'b0, 1'b1, 1);
        wait_done();

        // SRAM and DRAM address wrap
        gnt_mode = 1;
        start_cmd(31'h7FFF_FFC0, 8'd3, 8'd1, 12'h040, 8'hFF, 1'b1, 1'b0, 0);
        wait_done();

        // reset in the middle of a burst, then a fresh command
        start_cmd(31'h5000, 8'd7, 8'd1, 12'h100, 8'h60, 1'b0, 1'b0, 0);
        for (int i = 0; i < 500 && beat_tot < 3; i++) step();
        check_val("beats_before_rst", 128'(beat_tot >= 3), 128'(1));
        do_reset(1);
        check_quiet();
        start_cmd(31'h6000, 8'd3, 8'd0, 12'h000, 8'h80, 1'b1, 1'b0, 0);
        wait_done();

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
